uart_rx: RTL

- UART receive engine, 8N1 by default, using 16x oversampling.
- Consumes the baud-rate `tick_i` strobe produced by the block's companion generator, which ticks at f_clk / dvsr, with dvsr = f_clk / (baud * 16).
- Synchronizes the serial line, detects and validates the start bit, samples each bit at mid-bit, and presents the received byte with a one-cycle done strobe and a framing-error flag.
- Sits between the pad or line input and the RX FIFO or host register interface.

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_2ff.sv | 29 ++
 rtl/uart_rx.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and oversampling constants.
// Kept generic so the transmitter can reuse the same package.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int TICK_W     = 5;
  localparam int BIT_W      = 4;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// RST_VAL selects the level presented while in reset (idle level of the line).
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// UART receive engine with 16x oversampling: validates the start bit at its
// midpoint, samples data bits LSB first and reports framing errors.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            rx_i,
  input  logic            tick_i,
  output logic [DBIT-1:0] dout_o,
  output logic            rx_done_o,
  output logic            frame_err_o,
  output logic            busy_o
);

  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(MID_SAMPLE);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DBIT - 1);

  logic rx_s;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_i),
    .q_o    (rx_s)
  );

  rx_state_e         state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DBIT-1:0]   shift_q, shift_d;
  logic [DBIT-1:0]   dout_q, dout_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
  logic              busy_q, busy_d;
  // Cleared by a framing error so a held-low line (break) cannot re-arm
  // START until the line has been seen high again.
  logic              armed_q, armed_d;

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    dout_d     = dout_q;
    done_d     = 1'b0;
    ferr_d     = ferr_q;
    armed_d    = armed_q;

    unique case (state_q)
      IDLE: begin
        // A tick coinciding with the low-detect is deliberately not counted.
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end

      START: begin
        if (tick_i) begin
          if (tick_cnt_q == MID_TICK) begin
            if (!rx_s) begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (tick_i) begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s, shift_q[DBIT-1:1]};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              state_d = STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (tick_i) begin
          if (tick_cnt_q == STOP_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            dout_d  = shift_q;
            ferr_d  = ~rx_s;
            armed_d = rx_s;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      dout_q     <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
      armed_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      dout_q     <= dout_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
      armed_q    <= armed_d;
    end
  end

  assign dout_o      = dout_q;
  assign rx_done_o   = done_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = busy_q;

endmodule : uart_rx
